// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, access-size encodings and store lane helpers for the LSU
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  // funct3[1:0] selects the access size, funct3[2] marks an unsigned load
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Byte enables for a store; halves ignore off[0] so they always land on a half lane
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      SZ_B:    s = STRB_B << off;
      SZ_H:    s = STRB_H << {off[1], 1'b0};
      default: s = STRB_W;
    endcase
    return s;
  endfunction

  // Replicate the store operand across all lanes so the strobes alone pick the target bytes
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half of a read word and sign/zero-extends it
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select from the latched offset, then extend according to funct3
  always_comb begin
    byte_v   = rdata_i[{off_i, 3'b000} +: 8];
    half_v   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    case (funct3_i[1:0])
      SZ_B:    result_o = funct3_i[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    result_o = funct3_i[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with bus handshake and stall; optional MISALIGN_TRAP_EN
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [2:0]             funct3M,
  input  logic [ADDR_WIDTH-1:0]  ALUoutM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadDataM,
  output logic                   StallM,
  output logic                   misalignM,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wstrb,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
  output logic [STALL_CNT_W-1:0] stall_count
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              off_q, off_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [STALL_CNT_W-1:0]  cnt_q;
  logic [31:0]             load_ext;
  logic                    access;
  logic                    misaligned;
  logic                    stall;
  logic                    mis_flag;

  // Reset gates the request so StallM falls with rst even if the M-stage inputs are still set
  assign access = (MemReadM | MemWriteM) & ~rst;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = access &&
                      (((funct3M[1:0] == SZ_H) && ALUoutM[0]) ||
                       ((funct3M[1:0] == SZ_W) && (ALUoutM[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .result_o (load_ext)
  );

  // Next-state, request latching and stall/misalign generation
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    mis_flag = 1'b0;
    mem_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            mis_flag = 1'b1;
            rdata_d  = 32'h0;
          end else begin
            stall    = 1'b1;
            addr_d   = {ALUoutM[ADDR_WIDTH-1:2], 2'b00};
            we_d     = MemWriteM;
            wdata_d  = store_wdata(funct3M, WriteDataM);
            wstrb_d  = MemWriteM ? store_strb(funct3M, ALUoutM[1:0]) : 4'b0000;
            funct3_d = funct3M;
            off_d    = ALUoutM[1:0];
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          if (!we_q) rdata_d = load_ext;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request/response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
    end
  end

  // Saturating count of every cycle the pipeline is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ReadDataM   = rdata_q;
  assign StallM      = stall;
  assign misalignM   = mis_flag;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a delayed-ready bus responder
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALUoutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        misalignM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rd = 32'h0;

  load_store_unit #(.ADDR_WIDTH(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUoutM(ALUoutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .misalignM(misalignM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_rd = 32'h0;
  endtask

  // Drive one memory instruction, serve the bus after 'waitc' extra cycles, score the outcome
  task automatic do_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                           input int waitc, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rd, input int exp_stalls);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    logic [31:0] exp;
    MemReadM = rd;
    MemWriteM = wr;
    funct3M = f3;
    ALUoutM = addr;
    WriteDataM = wd;
    if (rd && !wr) sb.push_back(exp_rd);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (StallM) stalls++;
      if (mem_req) begin
        reqs++;
        check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_we"}, {31'b0, mem_we}, {31'b0, wr});
        if (wr) begin
          check({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_strb});
          check({tag, "_wdata"}, mem_wdata, exp_wdata);
        end
        mem_ready = (reqs > waitc);
        mem_rdata = rword;
      end else if (!StallM && reqs > 0) begin
        done = 1;
        if (rd && !wr) begin
          exp = sb.pop_front();
          check({tag, "_rdata"}, ReadDataM, exp);
          last_rd = exp;
        end else begin
          check({tag, "_rdata_held"}, ReadDataM, last_rd);
        end
      end
      @(posedge clk);
      #1 mem_ready = 1'b0;
    end
    if (!done) check({tag, "_timeout"}, 32'h0, 32'h1);
    check({tag, "_stalls"}, stalls, exp_stalls);
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  initial begin
    logic [15:0] sc0;
    apply_reset();
    @(negedge clk);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_stall", {31'b0, StallM}, 32'h0);
    check("rst_misalign", {31'b0, misalignM}, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    check("rst_cnt", {16'b0, stall_count}, 32'h0);
    @(posedge clk); #1;

    do_access("lw100", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 4'h0, 0, 32'hDEADBEEF, 2);
    check("cnt_after_lw", {16'b0, stall_count}, 32'd2);
    do_access("lb103", 1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0, 4'h0, 0, 32'hFFFFFF80, 2);
    do_access("lbu103", 1, 0, 3'b100, 32'h103, 0, 32'h80112233, 1, 4'h0, 0, 32'h00000080, 3);
    do_access("lb101", 1, 0, 3'b000, 32'h101, 0, 32'h80112233, 0, 4'h0, 0, 32'h00000022, 2);
    do_access("lh102", 1, 0, 3'b001, 32'h102, 0, 32'h80112233, 0, 4'h0, 0, 32'hFFFF8011, 2);
    do_access("lhu102", 1, 0, 3'b101, 32'h102, 0, 32'h80112233, 0, 4'h0, 0, 32'h00008011, 2);
    do_access("lh100", 1, 0, 3'b001, 32'h100, 0, 32'h12347FFF, 0, 4'h0, 0, 32'h00007FFF, 2);
    do_access("sh202", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, 4'b1100, 32'hABCDABCD, 0, 2);
    do_access("sb301", 0, 1, 3'b000, 32'h301, 32'h12345678, 0, 2, 4'b0010, 32'h78787878, 0, 4);
    do_access("sw400", 0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 0, 4'b1111, 32'hCAFEF00D, 0, 2);

    // Non-memory instructions: nothing moves
    sc0 = stall_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nop_stall", {31'b0, StallM}, 32'h0);
      check("nop_req", {31'b0, mem_req}, 32'h0);
      check("nop_rdata", ReadDataM, last_rd);
    end
    check("nop_cnt", {16'b0, stall_count}, {16'b0, sc0});
    @(posedge clk); #1;

    apply_reset();
    do_access("lw_wait3", 1, 0, 3'b010, 32'h108, 0, 32'h0BADF00D, 3, 4'h0, 0, 32'h0BADF00D, 5);
    check("cnt_wait3", {16'b0, stall_count}, 32'd5);

    // Reset while a request is outstanding
    MemReadM = 1'b1;
    funct3M = 3'b010;
    ALUoutM = 32'h200;
    begin
      bit seen = 0;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
        @(negedge clk);
        if (mem_req) seen = 1;
      end
      check("rstreq_seen", {31'b0, seen}, 32'h1);
    end
    rst = 1'b1;
    #1;
    check("rstreq_req", {31'b0, mem_req}, 32'h0);
    check("rstreq_stall", {31'b0, StallM}, 32'h0);
    MemReadM = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    last_rd = 32'h0;
    do_access("lw_after_rst", 1, 0, 3'b010, 32'h104, 0, 32'h13579BDF, 0, 4'h0, 0, 32'h13579BDF, 2);

`ifdef MISALIGN_TRAP_EN
    MemReadM = 1'b1;
    funct3M = 3'b010;
    ALUoutM = 32'h101;
    @(negedge clk);
    check("mis_flag", {31'b0, misalignM}, 32'h1);
    check("mis_stall", {31'b0, StallM}, 32'h0);
    check("mis_req", {31'b0, mem_req}, 32'h0);
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(negedge clk);
    check("mis_flag_clear", {31'b0, misalignM}, 32'h0);
    check("mis_req_after", {31'b0, mem_req}, 32'h0);
    check("mis_rdata", ReadDataM, 32'h0);
    @(posedge clk); #1;
`else
    do_access("lw101_forced", 1, 0, 3'b010, 32'h101, 0, 32'h89ABCDEF, 0, 4'h0, 0, 32'h89ABCDEF, 2);
    check("nomis_flag", {31'b0, misalignM}, 32'h0);
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
